// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM state encoding, default timing constants
// and the symbol bit convention used by decoder, playback and comparator.
package morse_pkg;

    // Receive FSM states (encoding is shared with other Morse blocks)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        EMIT  = 2'd3
    } morse_state_e;

    // Default timing, in milliseconds
    localparam int CLKS_PER_MS_DEF   = 50000;
    localparam int DOT_MAX_MS_DEF    = 200;
    localparam int LETTER_GAP_MS_DEF = 600;
    localparam int MAX_SYMBOLS_DEF   = 5;
    localparam int CNT_W_DEF         = 11;

    // code_out bit convention: 1 = dash, first symbol sits in the MSB of the
    // used bits, pattern is right-aligned
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/morse_key_decoder_ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLKS_PER_MS-1 and flags the wrap cycle.
// The synchronous clear restarts the count so a period starts at the clear.
module ms_tick_gen #(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Tick is the wrap cycle itself; a clear in the same cycle does not
    // swallow the tick that has already elapsed
    assign tick = enable && (cnt_q == LAST);

    // Next prescaler value: restart on clear or when disabled, wrap at LAST
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Prescaler register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key receiver: times key presses and pauses in milliseconds and
// turns them into dot/dash symbols and completed letter codes.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int CLKS_PER_MS   = CLKS_PER_MS_DEF,
    parameter int DOT_MAX_MS    = DOT_MAX_MS_DEF,
    parameter int LETTER_GAP_MS = LETTER_GAP_MS_DEF,
    parameter int MAX_SYMBOLS   = MAX_SYMBOLS_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   key_in,
    output logic                   sym_valid,
    output logic                   sym_is_dash,
    output logic [MAX_SYMBOLS-1:0] code_out,
    output logic [2:0]             code_len,
    output logic                   code_valid,
    output logic                   overflow_err
);

    localparam logic [CNT_W-1:0] DUR_MAX = '1;
    localparam logic [CNT_W-1:0] DOT_MAX = CNT_W'(DOT_MAX_MS);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(LETTER_GAP_MS);
    localparam logic [2:0]       SYM_MAX = 3'(MAX_SYMBOLS);

    morse_state_e           state_q, state_d;
    logic [CNT_W-1:0]       dur_q, dur_d;
    logic [MAX_SYMBOLS-1:0] sr_q, sr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   key_q;
    logic                   sym_valid_q, sym_valid_d;
    logic                   sym_is_dash_q, sym_is_dash_d;
    logic [MAX_SYMBOLS-1:0] code_out_q, code_out_d;
    logic [2:0]             code_len_q, code_len_d;
    logic                   code_valid_q, code_valid_d;
    logic                   overflow_err_q, overflow_err_d;

    logic                   tick;
    logic [CNT_W-1:0]       dur_now;
    logic                   is_dash;

    // Durations are measured from the key edge, so the prescaler restarts on
    // every change of key level
    ms_tick_gen #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clr    (key_in ^ key_q),
        .tick   (tick)
    );

    // Duration including a tick that lands in this very cycle (saturating)
    assign dur_now = (tick && (dur_q != DUR_MAX)) ? dur_q + 1'b1 : dur_q;
    assign is_dash = (dur_now > DOT_MAX);

    // Next-state, symbol/letter assembly and output pulse generation
    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        cnt_d          = cnt_q;
        sym_valid_d    = 1'b0;
        sym_is_dash_d  = sym_is_dash_q;
        code_out_d     = code_out_q;
        code_len_d     = code_len_q;
        code_valid_d   = 1'b0;
        overflow_err_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_in) begin
                        state_d = PRESS;
                    end
                end
                PRESS: begin
                    if (!key_in) begin
                        if (cnt_q == SYM_MAX) begin
                            overflow_err_d = 1'b1;
                            sr_d           = '0;
                            cnt_d          = '0;
                            state_d        = IDLE;
                        end else begin
                            sym_valid_d   = 1'b1;
                            sym_is_dash_d = is_dash;
                            sr_d          = MAX_SYMBOLS'({sr_q, is_dash});
                            cnt_d         = cnt_q + 3'd1;
                            state_d       = GAP;
                        end
                    end
                end
                GAP: begin
                    // An expiring gap takes priority over a new press
                    if (dur_now == GAP_END) begin
                        state_d      = EMIT;
                        code_valid_d = 1'b1;
                        code_out_d   = sr_q;
                        code_len_d   = cnt_q;
                    end else if (key_in) begin
                        state_d = PRESS;
                    end
                end
                EMIT: begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // Duration restarts on every state change and whenever disabled
        if (!enable || (state_d != state_q)) begin
            dur_d = '0;
        end else begin
            dur_d = dur_now;
        end
    end

    // State, counters and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            dur_q          <= '0;
            sr_q           <= '0;
            cnt_q          <= '0;
            key_q          <= 1'b0;
            sym_valid_q    <= 1'b0;
            sym_is_dash_q  <= 1'b0;
            code_out_q     <= '0;
            code_len_q     <= '0;
            code_valid_q   <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dur_q          <= dur_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            key_q          <= key_in;
            sym_valid_q    <= sym_valid_d;
            sym_is_dash_q  <= sym_is_dash_d;
            code_out_q     <= code_out_d;
            code_len_q     <= code_len_d;
            code_valid_q   <= code_valid_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign sym_valid    = sym_valid_q;
    assign sym_is_dash  = sym_is_dash_q;
    assign code_out     = code_out_q;
    assign code_len     = code_len_q;
    assign code_valid   = code_valid_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder with a 4-clock millisecond.
module tb_morse_key_decoder;

    localparam int MS = 4;

    localparam logic [1:0] K_SYM  = 2'd0;
    localparam logic [1:0] K_CODE = 2'd1;
    localparam logic [1:0] K_OVF  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       dash;
        logic [4:0] code;
        logic [2:0] len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       key_in = 1'b0;
    logic       sym_valid;
    logic       sym_is_dash;
    logic [4:0] code_out;
    logic [2:0] code_len;
    logic       code_valid;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    morse_key_decoder #(
        .CLKS_PER_MS   (MS),
        .DOT_MAX_MS    (3),
        .LETTER_GAP_MS (6),
        .MAX_SYMBOLS   (5),
        .CNT_W         (11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .key_in       (key_in),
        .sym_valid    (sym_valid),
        .sym_is_dash  (sym_is_dash),
        .code_out     (code_out),
        .code_len     (code_len),
        .code_valid   (code_valid),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic key_hold(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_sym(input logic dash);
        ev_t e;
        e = '{kind: K_SYM, dash: dash, code: 5'd0, len: 3'd0};
        exp_q.push_back(e);
    endtask

    task automatic exp_code(input logic [4:0] code, input logic [2:0] len);
        ev_t e;
        e = '{kind: K_CODE, dash: 1'b0, code: code, len: len};
        exp_q.push_back(e);
    endtask

    task automatic exp_ovf();
        ev_t e;
        e = '{kind: K_OVF, dash: 1'b0, code: 5'd0, len: 3'd0};
        exp_q.push_back(e);
    endtask

    // Monitor: pop and compare whenever the DUT pulses an output
    initial begin
        ev_t got;
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && (sym_valid || code_valid || overflow_err)) begin
                checks++;
                if (int'(sym_valid) + int'(code_valid) + int'(overflow_err) > 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive sym=%0d code=%0d ovf=%0d required at most one",
                             sym_valid, code_valid, overflow_err);
                end
                got.kind = sym_valid ? K_SYM : (code_valid ? K_CODE : K_OVF);
                got.dash = sym_valid ? sym_is_dash : 1'b0;
                got.code = code_valid ? code_out : 5'd0;
                got.len  = code_valid ? code_len : 3'd0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event kind=%0d dash=%0d code=%b len=%0d required none",
                             got.kind, got.dash, got.code, got.len);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL event got kind=%0d dash=%0d code=%b len=%0d required kind=%0d dash=%0d code=%b len=%0d",
                                 got.kind, got.dash, got.code, got.len, e.kind, e.dash, e.code, e.len);
                    end else begin
                        $display("event kind=%0d dash=%0d code=%b len=%0d ok",
                                 got.kind, got.dash, got.code, got.len);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset held low while the key toggles: outputs stay zero
        for (int i = 0; i < 3; i++) begin
            key_in = ~key_in;
            @(negedge clk);
            checks++;
            if ({sym_valid, sym_is_dash, code_out, code_len, code_valid, overflow_err} != '0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got=%b required all zero", i,
                         {sym_valid, sym_is_dash, code_out, code_len, code_valid, overflow_err});
            end
        end
        key_in = 1'b0;
        rst = 1'b1;
        key_hold(0, 10);

        // "A": dot (2 ms), 1 ms gap, dash (5 ms), letter gap
        exp_sym(1'b0); exp_sym(1'b1); exp_code(5'b00001, 3'd2);
        key_hold(1, 2*MS); key_hold(0, MS); key_hold(1, 5*MS); key_hold(0, 8*MS);

        // Boundaries: 3 ms dot, 4 ms dash, one-clock dot
        exp_sym(1'b0); exp_sym(1'b1); exp_sym(1'b0); exp_code(5'b00010, 3'd3);
        key_hold(1, 3*MS); key_hold(0, MS); key_hold(1, 4*MS); key_hold(0, MS);
        key_hold(1, 1); key_hold(0, 8*MS);

        // Full five-symbol letter: dash dot dash dot dash
        exp_sym(1'b1); exp_sym(1'b0); exp_sym(1'b1); exp_sym(1'b0); exp_sym(1'b1);
        exp_code(5'b10101, 3'd5);
        key_hold(1, 4*MS); key_hold(0, MS); key_hold(1, MS); key_hold(0, MS);
        key_hold(1, 4*MS); key_hold(0, MS); key_hold(1, MS); key_hold(0, MS);
        key_hold(1, 4*MS); key_hold(0, 8*MS);

        // Enable dropped mid-letter: partial letter vanishes, last code held
        exp_sym(1'b0); exp_sym(1'b1);
        key_hold(1, MS); key_hold(0, MS); key_hold(1, 4*MS); key_hold(0, 2);
        enable = 1'b0;
        key_hold(0, 6);
        checks++;
        if (code_out != 5'b10101) begin
            errors++;
            $display("FAIL hold_code_out got=%b required=%b", code_out, 5'b10101);
        end
        checks++;
        if (code_len != 3'd5) begin
            errors++;
            $display("FAIL hold_code_len got=%0d required=%0d", code_len, 5);
        end
        enable = 1'b1;
        key_hold(0, 8*MS);

        // Six dots: five symbols, then overflow on the sixth release
        for (int i = 0; i < 5; i++) exp_sym(1'b0);
        exp_ovf();
        for (int i = 0; i < 6; i++) begin
            key_hold(1, MS); key_hold(0, MS);
        end
        key_hold(0, 8*MS);

        // "E"
        exp_sym(1'b0); exp_code(5'b00000, 3'd1);
        key_hold(1, MS); key_hold(0, 8*MS);

        // "T"
        exp_sym(1'b1); exp_code(5'b00001, 3'd1);
        key_hold(1, 5*MS); key_hold(0, 8*MS);

        key_hold(0, 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d outstanding required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
